// File: rtl/mbc_power_sequencer_pkg.sv
// Shared types and constants for the MBC power-gate sequencer.
package mbc_pwr_pkg;

  // Sequencer states; encodings 6 and 7 are unused and recover to SLEEPING.
  typedef enum logic [2:0] {
    SLEEPING = 3'd0,
    WAKE_PWR = 3'd1,
    WAKE_RST = 3'd2,
    AWAKE    = 3'd3,
    SLP_ISO  = 3'd4,
    SLP_RST  = 3'd5
  } state_t;

  localparam int DEF_SETTLE_CYCLES = 4;
  localparam int DEF_GUARD_CYCLES  = 2;
  localparam int DEF_CNT_W         = 8;

  // Control levels presented to the MBC domain while sitting in a state.
  typedef struct packed {
    logic sleep;
    logic iso;
    logic rst;
    logic awake;
    logic busy;
  } pwr_out_t;

  // Output levels per state; anything unrecognised maps to the gated levels.
  function automatic pwr_out_t state_outputs(input state_t s);
    pwr_out_t o;
    case (s)
      SLEEPING: o = '{sleep: 1'b1, iso: 1'b1, rst: 1'b1, awake: 1'b0, busy: 1'b0};
      WAKE_PWR: o = '{sleep: 1'b0, iso: 1'b1, rst: 1'b1, awake: 1'b0, busy: 1'b1};
      WAKE_RST: o = '{sleep: 1'b0, iso: 1'b1, rst: 1'b0, awake: 1'b0, busy: 1'b1};
      AWAKE:    o = '{sleep: 1'b0, iso: 1'b0, rst: 1'b0, awake: 1'b1, busy: 1'b0};
      SLP_ISO:  o = '{sleep: 1'b0, iso: 1'b1, rst: 1'b0, awake: 1'b0, busy: 1'b1};
      SLP_RST:  o = '{sleep: 1'b0, iso: 1'b1, rst: 1'b1, awake: 1'b0, busy: 1'b1};
      default:  o = '{sleep: 1'b1, iso: 1'b1, rst: 1'b1, awake: 1'b0, busy: 1'b0};
    endcase
    return o;
  endfunction

endpackage

// File: rtl/mbc_power_sequencer_if.sv
// Request and power-control bundle between the always-on logic and the sequencer.
interface mbc_power_sequencer_if;
  logic SLEEP_REQ;
  logic WAKE_REQ;
  logic MBC_SLEEP;
  logic MBC_SLEEP_B;
  logic MBC_ISOLATE;
  logic MBC_ISOLATE_B;
  logic MBC_RESET;
  logic MBC_RESET_B;
  logic MBC_AWAKE;
  logic SEQ_BUSY;

  // Requester side: raises sleep/wake levels, observes the power controls.
  modport master (
    output SLEEP_REQ, WAKE_REQ,
    input  MBC_SLEEP, MBC_SLEEP_B, MBC_ISOLATE, MBC_ISOLATE_B,
           MBC_RESET, MBC_RESET_B, MBC_AWAKE, SEQ_BUSY
  );

  // Sequencer side: consumes requests, drives the power controls.
  modport slave (
    input  SLEEP_REQ, WAKE_REQ,
    output MBC_SLEEP, MBC_SLEEP_B, MBC_ISOLATE, MBC_ISOLATE_B,
           MBC_RESET, MBC_RESET_B, MBC_AWAKE, SEQ_BUSY
  );
endinterface

// File: rtl/mbc_power_sequencer_timer.sv
// Loadable down-counter shared by every timed sequencer state; holds at zero.
module mbc_pwr_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [CNT_W-1:0] value_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Load wins over counting; stop at zero so the flag stays asserted.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = value_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mbc_power_sequencer.sv
// Orders isolation, reset and header gating for the MBC domain on sleep and wake.
module mbc_power_sequencer
  import mbc_pwr_pkg::*;
#(
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int GUARD_CYCLES  = DEF_GUARD_CYCLES,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic                  CLKIN,
  input  logic                  RESETn,
  mbc_power_sequencer_if.slave  bus
);

  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GUARD_LD  = CNT_W'(GUARD_CYCLES - 1);

  state_t           state_q, state_d;
  pwr_out_t         out_d;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_value;
  logic             tmr_zero;

  logic sleep_q, sleep_b_q, iso_q, iso_b_q, rst_q, rst_b_q, awake_q, busy_q;

  mbc_pwr_timer #(.CNT_W(CNT_W)) u_timer (
    .clk_i   (CLKIN),
    .rst_ni  (RESETn),
    .load_i  (tmr_load),
    .value_i (tmr_value),
    .zero_o  (tmr_zero)
  );

  // Next-state and timer-load decision; power-down is never aborted once begun.
  always_comb begin
    state_d   = state_q;
    tmr_load  = 1'b0;
    tmr_value = '0;
    case (state_q)
      SLEEPING: if (bus.WAKE_REQ) begin
        state_d   = WAKE_PWR;
        tmr_load  = 1'b1;
        tmr_value = SETTLE_LD;
      end
      WAKE_PWR: if (tmr_zero) state_d = WAKE_RST;
      WAKE_RST: state_d = AWAKE;
      AWAKE: if (bus.SLEEP_REQ && !bus.WAKE_REQ) begin
        state_d   = SLP_ISO;
        tmr_load  = 1'b1;
        tmr_value = GUARD_LD;
      end
      SLP_ISO: if (tmr_zero) begin
        state_d   = SLP_RST;
        tmr_load  = 1'b1;
        tmr_value = GUARD_LD;
      end
      SLP_RST: if (tmr_zero) state_d = SLEEPING;
      default: state_d = SLEEPING;
    endcase
  end

  assign out_d = state_outputs(state_d);

  // State and output flops; each complement has its own flop so no port sees decode logic.
  always_ff @(posedge CLKIN or negedge RESETn) begin
    if (!RESETn) begin
      state_q   <= SLEEPING;
      sleep_q   <= 1'b1;
      sleep_b_q <= 1'b0;
      iso_q     <= 1'b1;
      iso_b_q   <= 1'b0;
      rst_q     <= 1'b1;
      rst_b_q   <= 1'b0;
      awake_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sleep_q   <= out_d.sleep;
      sleep_b_q <= ~out_d.sleep;
      iso_q     <= out_d.iso;
      iso_b_q   <= ~out_d.iso;
      rst_q     <= out_d.rst;
      rst_b_q   <= ~out_d.rst;
      awake_q   <= out_d.awake;
      busy_q    <= out_d.busy;
    end
  end

  assign bus.MBC_SLEEP     = sleep_q;
  assign bus.MBC_SLEEP_B   = sleep_b_q;
  assign bus.MBC_ISOLATE   = iso_q;
  assign bus.MBC_ISOLATE_B = iso_b_q;
  assign bus.MBC_RESET     = rst_q;
  assign bus.MBC_RESET_B   = rst_b_q;
  assign bus.MBC_AWAKE     = awake_q;
  assign bus.SEQ_BUSY      = busy_q;

endmodule

// File: tb/tb_mbc_power_sequencer.sv
// Bench for mbc_power_sequencer: vector table, corner sequences and a schedule-based model.
module tb_mbc_power_sequencer;
  import mbc_pwr_pkg::*;

  localparam int SETTLE = 4;
  localparam int GUARD  = 2;

  // Expected {SLEEP, ISO, RST, AWAKE, BUSY} snapshots.
  localparam logic [4:0] O_SLP  = 5'b11100;
  localparam logic [4:0] O_WP   = 5'b01101;
  localparam logic [4:0] O_WR   = 5'b01001;
  localparam logic [4:0] O_AW   = 5'b00010;
  localparam logic [4:0] O_ISO  = 5'b01001;
  localparam logic [4:0] O_RSTH = 5'b01101;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mbc_power_sequencer_if bus();

  mbc_power_sequencer #(
    .SETTLE_CYCLES (SETTLE),
    .GUARD_CYCLES  (GUARD),
    .CNT_W         (8)
  ) dut (
    .CLKIN  (clk),
    .RESETn (rst_n),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [4:0] act, input logic [4:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b expected=%b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] outs();
    return {bus.MBC_SLEEP, bus.MBC_ISOLATE, bus.MBC_RESET, bus.MBC_AWAKE, bus.SEQ_BUSY};
  endfunction

  task automatic step(input logic s, input logic w);
    @(negedge clk);
    bus.SLEEP_REQ = s;
    bus.WAKE_REQ  = w;
    @(posedge clk);
    #1;
  endtask

  // Reference model: a wake or sleep decision schedules the whole output
  // sequence up front; requests are only looked at when nothing is scheduled.
  logic [4:0] m_q[$];
  logic [4:0] m_exp;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_exp = O_SLP;
    end else begin
      if (m_q.size() == 0) begin
        if (m_exp == O_SLP && bus.WAKE_REQ) begin
          repeat (SETTLE) m_q.push_back(O_WP);
          m_q.push_back(O_WR);
          m_q.push_back(O_AW);
        end else if (m_exp == O_AW && bus.SLEEP_REQ && !bus.WAKE_REQ) begin
          repeat (GUARD) m_q.push_back(O_ISO);
          repeat (GUARD) m_q.push_back(O_RSTH);
          m_q.push_back(O_SLP);
        end
      end
      if (m_q.size() != 0) m_exp = m_q.pop_front();
    end
  end

  // Ordering invariants and true/complement pairing, every cycle out of reset.
  logic p_sleep = 1'b1, p_iso = 1'b1, p_rst = 1'b1;
  always @(negedge clk) begin
    if (rst_n) begin
      chk("complement", {2'b00, bus.MBC_SLEEP_B, bus.MBC_ISOLATE_B, bus.MBC_RESET_B},
          {2'b00, ~bus.MBC_SLEEP, ~bus.MBC_ISOLATE, ~bus.MBC_RESET});
      chk("order_inv",
          {4'b0000, (bus.MBC_ISOLATE || (!bus.MBC_RESET && !bus.MBC_SLEEP)) &&
                    (bus.MBC_RESET || !bus.MBC_SLEEP)},
          5'b00001);
      if (bus.MBC_SLEEP != p_sleep)
        chk("sleep_edge", {1'b0, p_iso, p_rst, bus.MBC_ISOLATE, bus.MBC_RESET}, 5'b01111);
    end
    p_sleep = bus.MBC_SLEEP;
    p_iso   = bus.MBC_ISOLATE;
    p_rst   = bus.MBC_RESET;
  end

  typedef struct {
    logic       s;
    logic       w;
    logic [4:0] exp;
  } vec_t;
  vec_t tbl[15];

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.SLEEP_REQ = 1'b0;
    bus.WAKE_REQ  = 1'b0;

    tbl[0]  = '{1'b0, 1'b0, O_SLP};
    tbl[1]  = '{1'b1, 1'b0, O_SLP};
    tbl[2]  = '{1'b0, 1'b1, O_WP};
    tbl[3]  = '{1'b1, 1'b0, O_WP};
    tbl[4]  = '{1'b0, 1'b0, O_WP};
    tbl[5]  = '{1'b0, 1'b0, O_WP};
    tbl[6]  = '{1'b0, 1'b0, O_WR};
    tbl[7]  = '{1'b1, 1'b0, O_AW};
    tbl[8]  = '{1'b1, 1'b1, O_AW};
    tbl[9]  = '{1'b1, 1'b0, O_ISO};
    tbl[10] = '{1'b0, 1'b1, O_ISO};
    tbl[11] = '{1'b0, 1'b1, O_RSTH};
    tbl[12] = '{1'b0, 1'b0, O_RSTH};
    tbl[13] = '{1'b0, 1'b1, O_SLP};
    tbl[14] = '{1'b0, 1'b1, O_WP};

    #12;
    chk("reset_out", outs(), O_SLP);
    chk("reset_comp", {2'b00, bus.MBC_SLEEP_B, bus.MBC_ISOLATE_B, bus.MBC_RESET_B}, 5'b00000);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      step(tbl[i].s, tbl[i].w);
      chk($sformatf("vec%0d", i), outs(), tbl[i].exp);
    end

    // Asynchronous reset in the middle of the wake sequence.
    step(1'b0, 1'b0);
    chk("pre_async", outs(), O_WP);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_out", outs(), O_SLP);
    chk("async_reset_comp", {2'b00, bus.MBC_SLEEP_B, bus.MBC_ISOLATE_B, bus.MBC_RESET_B}, 5'b00000);
    @(negedge clk);
    rst_n = 1'b1;

    // Simultaneous requests in AWAKE: wake wins, nothing moves.
    step(1'b0, 1'b1);
    repeat (5) step(1'b0, 1'b0);
    chk("wake_done", outs(), O_AW);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b1);
      chk($sformatf("both_req%0d", i), outs(), O_AW);
    end
    step(1'b1, 1'b0);
    chk("drop_wake", outs(), O_ISO);

    // Wake pulse during isolate-hold is dropped.
    step(1'b0, 1'b1); chk("pulse_iso", outs(), O_ISO);
    step(1'b0, 1'b0); chk("pulse_rst0", outs(), O_RSTH);
    step(1'b0, 1'b0); chk("pulse_rst1", outs(), O_RSTH);
    step(1'b0, 1'b0); chk("pulse_slp", outs(), O_SLP);
    step(1'b0, 1'b0); chk("no_latched_wake", outs(), O_SLP);

    // Wake held through reset-hold restarts one edge after SLEEPING.
    step(1'b0, 1'b1);
    repeat (5) step(1'b0, 1'b0);
    chk("wake_again", outs(), O_AW);
    step(1'b1, 1'b0); chk("held_iso0", outs(), O_ISO);
    step(1'b0, 1'b0); chk("held_iso1", outs(), O_ISO);
    step(1'b0, 1'b1); chk("held_rst0", outs(), O_RSTH);
    step(1'b0, 1'b1); chk("held_rst1", outs(), O_RSTH);
    step(1'b0, 1'b1); chk("held_slp", outs(), O_SLP);
    step(1'b0, 1'b1); chk("held_rewake", outs(), O_WP);

    // Illegal state encoding recovers to the gated state.
    @(negedge clk);
    bus.WAKE_REQ = 1'b0;
    force dut.state_q = state_t'(3'd7);
    @(posedge clk);
    #1;
    chk("illegal_recover", outs(), O_SLP);
    release dut.state_q;
    step(1'b0, 1'b0);
    chk("illegal_settle", outs(), O_SLP);

    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Random request traffic against the schedule model.
    for (int i = 0; i < 1000; i++) begin
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
      chk("model", outs(), m_exp);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
